// File: rtl/cache_wbuf_ctrl_if.sv
// Bus bundle between the data cache, the write-back buffer controller and main memory.
// slave = controller side, master = cache/memory environment side.
interface cache_wbuf_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  wbuf_count;

    modport slave (
        input  cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
        output cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata, wbuf_count
    );

    modport master (
        output cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
        input  cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata, wbuf_count
    );
endinterface

// File: rtl/cache_wbuf_ctrl.sv
// Write-back buffer and memory arbiter between the data cache and main memory; state moves on negedge clk.
// Define WBUF_COALESCE_EN to merge a write into an already-buffered entry with the same address.
module cache_wbuf_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic             clk,
    input  logic             proc_reset,
    cache_wbuf_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              hit;
    logic [PTR_W-1:0]  hit_idx, scan_idx;
    logic              coalesce;
    logic              store_en;
    logic [PTR_W-1:0]  store_idx;

    // Scan oldest to newest so the last match wins: that is the newest copy of the block.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = head_q;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] && addr_q[scan_idx] == bus.cache_addr) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

`ifdef WBUF_COALESCE_EN
    assign coalesce = bus.cache_write && hit;
`else
    assign coalesce = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        store_en    = 1'b0;
        store_idx   = tail_q;
        case (state_q)
            IDLE: begin
                if (coalesce) begin
                    store_en  = 1'b1;
                    store_idx = hit_idx;
                    state_d   = RESP;
                end else if (bus.cache_write && count_q != FULL) begin
                    store_en        = 1'b1;
                    valid_d[tail_q] = 1'b1;
                    tail_d          = tail_q + 1'b1;
                    count_d         = count_q + 1'b1;
                    state_d         = RESP;
                end else if (bus.cache_read && !bus.cache_write && hit) begin
                    rdata_d = data_q[hit_idx];
                    state_d = RESP;
                end else if (bus.cache_read && !bus.cache_write) begin
                    mem_addr_d = bus.cache_addr;
                    mem_read_d = 1'b1;
                    state_d    = RD_MEM;
                end else if (count_q != '0) begin
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                    mem_write_d = 1'b1;
                    state_d     = WR_MEM;
                end
            end
            RD_MEM: begin
                if (bus.mem_ready) begin
                    rdata_d    = bus.mem_rdata;
                    mem_read_d = 1'b0;
                    state_d    = RESP;
                end
            end
            WR_MEM: begin
                if (bus.mem_ready) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    count_d         = count_q - 1'b1;
                    mem_write_d     = 1'b0;
                    state_d         = IDLE;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Entry payload needs no reset: valid_q alone decides what is live.
    always_ff @(negedge clk) begin
        if (store_en) begin
            addr_q[store_idx] <= bus.cache_addr;
            data_q[store_idx] <= bus.cache_wdata;
        end
    end

    assign bus.cache_rdata = rdata_q;
    assign bus.cache_ready = ready_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.wbuf_count  = count_q;
endmodule

// File: tb/tb_cache_wbuf_ctrl.sv
// Self-checking bench for cache_wbuf_ctrl: vector table plus hand-written multi-cycle sequences,
// with a scoreboard tracking cache responses, memory reads and the buffered blocks awaiting drain.
module tb_cache_wbuf_ctrl;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef struct {
        bit           isRead;
        logic [127:0] data;
    } resp_t;

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
    } entry_t;

    typedef struct {
        bit           isWrite;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [127:0] expRdata;
        int           expCount;
    } vec_t;

    logic clk = 1'b0;
    logic proc_reset;

    cache_wbuf_ctrl_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_wbuf_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    resp_t        expRespQ[$];
    entry_t       modelBuf[$];
    logic [27:0]  expMemRdQ[$];
    int           checks = 0;
    int           failures = 0;
    bit           memAuto = 1'b0;
    int           memLat = 1;
    int           waitCnt = 0;
    int           pulseReq = 0;
    logic [127:0] memRdataVal = '0;
    int           memWriteCount = 0;
    int           firstMemOp = 0;
`ifdef WBUF_COALESCE_EN
    bit           coal = 1'b1;
`else
    bit           coal = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=missing_or_unexpected_event required=expected_event", name);
    endtask

    function automatic void modelWrite(input logic [27:0] addr, input logic [127:0] data);
        entry_t e;
`ifdef WBUF_COALESCE_EN
        for (int i = modelBuf.size() - 1; i >= 0; i--) begin
            if (modelBuf[i].addr == addr) begin
                modelBuf[i].data = data;
                return;
            end
        end
`endif
        e.addr = addr;
        e.data = data;
        modelBuf.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cache request starting now; returns one time unit after cache_ready is seen,
    // with strobes dropped so a following call can issue the next request back-to-back.
    task automatic applyStimulus(input bit isWrite, input logic [27:0] addr, input logic [127:0] data,
                                 input logic [127:0] expRdata, output int cycles);
        resp_t r;
        r.isRead = !isWrite;
        r.data   = expRdata;
        expRespQ.push_back(r);
        bus.cache_write = isWrite;
        bus.cache_read  = !isWrite;
        bus.cache_addr  = addr;
        bus.cache_wdata = data;
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            if (bus.cache_ready) break;
        end
        if (!bus.cache_ready) failNote("cache_ready_timeout");
        else if (isWrite) modelWrite(addr, data);
        #1;
        bus.cache_write = 1'b0;
        bus.cache_read  = 1'b0;
    endtask

    task automatic stallMem();
        memAuto  = 1'b0;
        pulseReq = 0;
    endtask

    task automatic waitIdle();
        int n;
        waitCnt = 0;
        memLat  = 1;
        memAuto = 1'b1;
        n = 0;
        while (n < 500) begin
            tick();
            n++;
            if (bus.wbuf_count == 0 && !bus.mem_write && !bus.mem_read && !bus.cache_ready) break;
        end
        checkOutput("drain_count", 128'(bus.wbuf_count), 128'(0));
        checkOutput("model_empty", 128'(modelBuf.size()), 128'(0));
    endtask

    // Memory model: either auto-completes after memLat strobe cycles or replays manual pulses.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rdata = memRdataVal;
            if (memAuto) begin
                if (bus.mem_ready) begin
                    bus.mem_ready = 1'b0;
                    waitCnt = 0;
                end else if (bus.mem_read || bus.mem_write) begin
                    waitCnt++;
                    if (waitCnt >= memLat) bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = (pulseReq > 0);
                if (pulseReq > 0) pulseReq--;
            end
        end
    end

    // Scoreboard consumer: a transaction completes on the negedge after strobe and mem_ready are both seen.
    initial begin : monitor
        entry_t      e;
        resp_t       r;
        logic [27:0] a;
        forever begin
            @(posedge clk);
            #2;
            if (!proc_reset) begin
                if ((bus.mem_read || bus.mem_write) && firstMemOp == 0) firstMemOp = bus.mem_read ? 1 : 2;
                if (bus.mem_read && bus.mem_ready) begin
                    if (expMemRdQ.size() == 0) failNote("unexpected_mem_read");
                    else begin
                        a = expMemRdQ.pop_front();
                        checkOutput("mem_read_addr", 128'(bus.mem_addr), 128'(a));
                    end
                end
                if (bus.mem_write && bus.mem_ready) begin
                    memWriteCount++;
                    if (modelBuf.size() == 0) failNote("unexpected_mem_write");
                    else begin
                        e = modelBuf.pop_front();
                        checkOutput("mem_write_addr", 128'(bus.mem_addr), 128'(e.addr));
                        checkOutput("mem_write_data", bus.mem_wdata, e.data);
                    end
                end
                if (bus.cache_ready) begin
                    if (expRespQ.size() == 0) failNote("unexpected_cache_ready");
                    else begin
                        r = expRespQ.pop_front();
                        if (r.isRead) checkOutput("cache_rdata", bus.cache_rdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        failNote("global_watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t         vecs[7];
        int           cyc;
        int           w0;
        logic [127:0] dA5, dX, dY;
        dA5 = {16{8'hA5}};
        dX  = {8{16'h1111}};
        dY  = {8{16'h2222}};
        vecs[0] = '{isWrite: 1'b1, addr: 28'h100, data: {8{16'hD0D0}}, expRdata: '0, expCount: 1};
        vecs[1] = '{isWrite: 1'b1, addr: 28'h101, data: {8{16'hD1D1}}, expRdata: '0, expCount: 2};
        vecs[2] = '{isWrite: 1'b0, addr: 28'h100, data: '0, expRdata: {8{16'hD0D0}}, expCount: 2};
        vecs[3] = '{isWrite: 1'b1, addr: 28'h100, data: {8{16'hD2D2}}, expRdata: '0, expCount: coal ? 2 : 3};
        vecs[4] = '{isWrite: 1'b0, addr: 28'h100, data: '0, expRdata: {8{16'hD2D2}}, expCount: coal ? 2 : 3};
        vecs[5] = '{isWrite: 1'b0, addr: 28'h101, data: '0, expRdata: {8{16'hD1D1}}, expCount: coal ? 2 : 3};
        vecs[6] = '{isWrite: 1'b1, addr: 28'h102, data: {8{16'hD3D3}}, expRdata: '0, expCount: coal ? 3 : 4};

        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
        bus.cache_addr  = '0;
        bus.cache_wdata = '0;
        proc_reset      = 1'b0;
        #2 proc_reset   = 1'b1;
        tick();
        checkOutput("rst_cache_ready", 128'(bus.cache_ready), 128'(0));
        checkOutput("rst_cache_rdata", bus.cache_rdata, 128'(0));
        checkOutput("rst_mem_read", 128'(bus.mem_read), 128'(0));
        checkOutput("rst_mem_write", 128'(bus.mem_write), 128'(0));
        checkOutput("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        checkOutput("rst_mem_wdata", bus.mem_wdata, 128'(0));
        checkOutput("rst_wbuf_count", 128'(bus.wbuf_count), 128'(0));
        tick();
        proc_reset = 1'b0;

        // Single write with a slow memory: ack latency, then the drain holds addr/data.
        tick();
        waitCnt = 0;
        memLat  = 5;
        memAuto = 1'b1;
        applyStimulus(1'b1, 28'h0000010, dA5, '0, cyc);
        checkOutput("write_latency", 128'(cyc), 128'(2));
        checkOutput("write_count", 128'(bus.wbuf_count), 128'(1));
        tick();
        tick();
        checkOutput("drain_mem_write", 128'(bus.mem_write), 128'(1));
        checkOutput("drain_mem_addr", 128'(bus.mem_addr), 128'(28'h0000010));
        checkOutput("drain_mem_wdata", bus.mem_wdata, dA5);
        checkOutput("drain_count_held", 128'(bus.wbuf_count), 128'(1));
        waitIdle();

        // Forwarding hit while memory is stalled: first memory activity must be the drain, not a read.
        stallMem();
        tick();
        firstMemOp = 0;
        applyStimulus(1'b1, 28'h0000020, {4{32'hD1D1_0001}}, '0, cyc);
        applyStimulus(1'b0, 28'h0000020, '0, {4{32'hD1D1_0001}}, cyc);
        checkOutput("fwd_latency", 128'(cyc), 128'(2));
        checkOutput("fwd_no_mem_read", 128'(bus.mem_read), 128'(0));
        tick();
        tick();
        checkOutput("fwd_first_mem_op", 128'(firstMemOp), 128'(2));
        waitIdle();

        // Table of back-to-back requests against a stalled memory.
        stallMem();
        tick();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].expRdata, cyc);
            checkOutput("vec_latency", 128'(cyc), 128'(2));
            checkOutput("vec_count", 128'(bus.wbuf_count), 128'(vecs[i].expCount));
        end
        waitIdle();

        // Full buffer: the fifth write waits until one drain frees a slot.
        stallMem();
        tick();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 28'(i), {16{8'(i)}}, '0, cyc);
        checkOutput("fill_count", 128'(bus.wbuf_count), 128'(4));
        fork
            applyStimulus(1'b1, 28'h5, {16{8'h55}}, '0, cyc);
            begin
                repeat (4) begin
                    @(posedge clk);
                    checkOutput("full_no_ready", 128'(bus.cache_ready), 128'(0));
                end
                checkOutput("full_count", 128'(bus.wbuf_count), 128'(4));
                checkOutput("full_drain_write", 128'(bus.mem_write), 128'(1));
                checkOutput("full_drain_addr", 128'(bus.mem_addr), 128'(28'h1));
                pulseReq = 1;
            end
        join
        checkOutput("full_accept_count", 128'(bus.wbuf_count), 128'(4));
        waitIdle();

        // Read miss with two blocks buffered: the read goes to memory before any drain.
        memRdataVal = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        waitCnt = 0;
        memLat  = 2;
        memAuto = 1'b1;
        tick();
        firstMemOp = 0;
        applyStimulus(1'b1, 28'h0000040, {4{32'h4040_4040}}, '0, cyc);
        applyStimulus(1'b1, 28'h0000041, {4{32'h4141_4141}}, '0, cyc);
        expMemRdQ.push_back(28'h0000033);
        applyStimulus(1'b0, 28'h0000033, '0, memRdataVal, cyc);
        checkOutput("miss_first_mem_op", 128'(firstMemOp), 128'(1));
        checkOutput("miss_count", 128'(bus.wbuf_count), 128'(2));
        waitIdle();

        // Two writes to one address: merged or kept as separate entries.
        stallMem();
        tick();
        w0 = memWriteCount;
        applyStimulus(1'b1, 28'h7, dX, '0, cyc);
        applyStimulus(1'b1, 28'h7, dY, '0, cyc);
        checkOutput("dup_count", 128'(bus.wbuf_count), 128'(coal ? 1 : 2));
        waitIdle();
        checkOutput("dup_mem_writes", 128'(memWriteCount - w0), 128'(coal ? 1 : 2));

        // Reset during a drain drops the strobe and the buffer at once.
        stallMem();
        tick();
        applyStimulus(1'b1, 28'h0000060, {4{32'h6060_6060}}, '0, cyc);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.mem_write) break;
        end
        checkOutput("pre_reset_mem_write", 128'(bus.mem_write), 128'(1));
        proc_reset = 1'b1;
        #1;
        checkOutput("async_rst_mem_write", 128'(bus.mem_write), 128'(0));
        checkOutput("async_rst_count", 128'(bus.wbuf_count), 128'(0));
        checkOutput("async_rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        modelBuf.delete();
        expRespQ.delete();
        expMemRdQ.delete();
        tick();
        tick();
        proc_reset = 1'b0;
        waitCnt = 0;
        memAuto = 1'b1;
        repeat (4) tick();
        checkOutput("post_rst_no_drain", 128'(bus.mem_write), 128'(0));
        checkOutput("post_rst_count", 128'(bus.wbuf_count), 128'(0));

        checkOutput("resp_queue_empty", 128'(expRespQ.size()), 128'(0));
        checkOutput("memrd_queue_empty", 128'(expMemRdQ.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
